fifo_burst_drain: RTL
=====================

# fifo_burst_drain

Downstream read-side stage for the 32-bit FIFO block. It pulls words from the FIFO through the `Read_enable`/`empty`/`data_out` port set, where the FIFO registers `data_out` one clock after a granted read. It re-presents the words on a valid/ready stream with a small prefetch buffer, so backpressure never loses data. It also marks every `BURST_LEN`-th word with `out_last` so the consumer can frame fixed-size bursts.

## Interface
- `DATA_WIDTH`, 32, word width; matches the FIFO data path.
- `BUF_DEPTH`, 2, prefetch buffer entries; minimum 2, power of two.
- `BURST_LEN`, 8, words per burst; range 1..65535.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; the same net that drives the FIFO reset.
- `enable`  in  1  permits new FIFO reads; buffered words drain regardless.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`.
- `fifo_rd_en`  out  1  drives FIFO `Read_enable`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word when high together with `out_valid`.
- `out_data`  out  DATA_WIDTH  head word of the buffer.
- `out_last`  out  1  head word is the last word of a burst.
- `busy`  out  1  buffer non-empty or a FIFO read is in flight.
- `out_parity`  out  1  even parity of `out_data`; present only with `FIFO_DRAIN_PARITY_EN`.

## Operation
- State:
  - `count`: buffer occupancy, 0..BUF_DEPTH.
  - `pending`: 1-bit; a read was granted last cycle.
  - Circular buffer with `wr_idx` and `rd_idx`, each log2(BUF_DEPTH) bits, wrapping naturally.
  - `beat_cnt`: 16 bits.
- Pop: `pop = out_valid & out_ready`.
- Read issue: `fifo_rd_en = enable & ~fifo_empty & ~reset & ((count + pending - pop) < BUF_DEPTH)`. This is combinational. It never asserts while `fifo_empty` is high.
- `pending <= fifo_rd_en` each clock.
- Capture: when `pending` is 1, `fifo_data` is written into `buf[wr_idx]` and `wr_idx` increments.
- Count update: `count` changes by +pending −pop. A simultaneous capture and pop leaves `count` unchanged.
- Output: `out_valid = (count != 0)`. `out_data = buf[rd_idx]`. `rd_idx` increments on pop.
- Burst framing:
  - `out_last = out_valid & (beat_cnt == BURST_LEN-1)`.
  - On pop, `beat_cnt` goes to 0 if `out_last`, else increments.
  - `beat_cnt` only advances on pop; stalls do not disturb it.
- `busy = (count != 0) | pending`.
- Deasserting `enable` stops new reads only. An in-flight read still lands in the buffer. Words already in the buffer are still offered.
- Overflow is impossible by construction. The bench asserts that a capture never occurs while `count == BUF_DEPTH` with no pop.

## Timing
- Reset, sampled at posedge:
  - `count`, `pending`, `wr_idx`, `rd_idx` and `beat_cnt` go to 0.
  - Outputs `out_valid`, `out_last`, `busy`, `out_parity` and `out_data` read 0; buffer contents are cleared.
  - `fifo_rd_en` is held 0 while `reset` is high.
- Reset mid-burst: partial burst and buffered words are discarded. The next word after reset is beat 0.
- Latency: `fifo_rd_en` high in cycle N → `pending` high in N+1 with `fifo_data` valid → `out_valid` high in N+2.
- Throughput: with `out_ready` held high and the FIFO non-empty, one word per cycle in steady state.
- Stall: `out_data` and `out_last` are held stable while `out_valid & ~out_ready`.
- Read issue stops once the buffer plus in-flight read reaches `BUF_DEPTH`. It resumes in the same cycle as a pop.

## Configuration
- `FIFO_DRAIN_PARITY_EN` defined:
  - Port `out_parity = ^out_data`, combinational from the head entry.
  - Reads 0 when `out_valid` is 0.
- `FIFO_DRAIN_PARITY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then write 3 words (0xA0..0xA2) into the FIFO with `enable=1` and `out_ready=1` → `out_data` sequence 0xA0, 0xA1, 0xA2 on consecutive cycles. First `out_valid` occurs 2 cycles after the first `fifo_rd_en`. `busy` returns to 0.
- `BURST_LEN=4`, stream 10 words → `out_last` high on words 3 and 7 (0-based) only. `beat_cnt` is 2 after the stream.
- Fill the FIFO with 8 words, `out_ready=0` → exactly 2 `fifo_rd_en` pulses, `count=2`, `out_data` held at word 0. Release `out_ready` → all 8 words arrive in order with no duplicates or drops.
- Toggle `out_ready` 1,0 repeatedly while streaming 0x100..0x10F → consumer receives all 16 in order. `fifo_rd_en` never asserts while `fifo_empty=1`.
- Drop `enable` mid-stream with a read in flight → that word still appears on `out_data`. No further `fifo_rd_en` is issued. `busy` falls once the buffer drains.
- Assert `reset` for 1 cycle with `count=2` mid-burst → next cycle `out_valid=0` and `busy=0`. The next word carries beat 0. With `FIFO_DRAIN_PARITY_EN`, word 0x00000007 gives `out_parity=1`.

Source files
------------

// File: rtl/fifo_burst_drain.sv
// FIFO read-side drain: prefetches into a BUF_DEPTH buffer, re-presents words on valid/ready, flags every BURST_LEN-th word.
// Data reaches out_valid two cycles after fifo_rd_en; reads stop when buffer + in-flight fills. Option: FIFO_DRAIN_PARITY_EN.
module fifo_burst_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 2,
   parameter int BURST_LEN  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy
`ifdef FIFO_DRAIN_PARITY_EN
   ,
   output logic                  out_parity
`endif
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(BUF_DEPTH);
   localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

   logic [CW-1:0]         count_q, count_d;
   logic                  pending_q, pending_d;
   logic [AW-1:0]         wr_idx_q, wr_idx_d;
   logic [AW-1:0]         rd_idx_q, rd_idx_d;
   logic [15:0]           beat_cnt_q, beat_cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
   logic                  pop;
   logic [CW:0]           committed;

   // Slots already claimed (buffered + in flight) after this cycle's pop decide whether to read again.
   always_comb begin
      out_valid  = (count_q != '0);
      out_data   = mem_q[rd_idx_q];
      out_last   = out_valid & (beat_cnt_q == LAST_BEAT);
      busy       = out_valid | pending_q;
      pop        = out_valid & out_ready;
      committed  = {1'b0, count_q} + {{CW{1'b0}}, pending_q} - {{CW{1'b0}}, pop};
      fifo_rd_en = enable & ~fifo_empty & ~reset & (committed < DEPTH_LIM);
   end

   always_comb begin
      mem_d      = mem_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      beat_cnt_d = beat_cnt_q;
      pending_d  = fifo_rd_en;
      count_d    = count_q + CW'(pending_q) - CW'(pop);
      if (pending_q) begin
         mem_d[wr_idx_q] = fifo_data;
         wr_idx_d        = wr_idx_q + AW'(1);
      end
      if (pop) begin
         rd_idx_d   = rd_idx_q + AW'(1);
         beat_cnt_d = out_last ? 16'd0 : beat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         pending_q  <= 1'b0;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         beat_cnt_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q    <= count_d;
         pending_q  <= pending_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         beat_cnt_q <= beat_cnt_d;
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

`ifdef FIFO_DRAIN_PARITY_EN
   assign out_parity = out_valid & (^out_data);
`endif

endmodule
